// File: rtl/seq_pipe_pkg.sv
// rtl/seq_pipe_pkg.sv - shared constants and types for the delay pipe and its credit queue
package seq_pipe_pkg;
    localparam int DEFAULT_WIDTH = 8;
    localparam int PIPE_LATENCY  = 3;
    typedef logic [DEFAULT_WIDTH-1:0] data_t;
endpackage

// File: rtl/seq_pipe_credit_fifo.sv
// rtl/seq_pipe_credit_fifo.sv - DEPTH x WIDTH circular buffer with modular pointers and occupancy count
module seq_pipe_credit_fifo import seq_pipe_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_eff;
    logic             pop_eff;

    // DEPTH need not be a power of two, so wrap explicitly
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_eff  = pop && !empty;
    assign push_eff = push && (!full || pop_eff);
    assign rdata    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_eff)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_eff, pop_eff})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/seq_pipe_delay_credit_queue.sv
// rtl/seq_pipe_delay_credit_queue.sv - credit-gated capture queue behind the fixed-latency delay pipe
module seq_pipe_delay_credit_queue import seq_pipe_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue,
    output logic             issue_ok,
    input  logic             in_val,
    input  logic [WIDTH-1:0] in_,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out,
    output logic [CW-1:0]    count,
    output logic             overflow
);
    logic [CW-1:0]    inflight;
    logic [CW:0]      committed;
    logic [WIDTH-1:0] head;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push;
    logic             issue_acc;
    logic             arrive;

    // Credits count queued plus in-pipe items; both are registers, so no input reaches issue_ok
    assign committed = {1'b0, count} + {1'b0, inflight};
    assign issue_ok  = (committed < (CW + 1)'(DEPTH));
    assign issue_acc = issue && issue_ok;
    assign arrive    = in_val && (inflight != '0);

    assign out_val = !empty;
    assign out     = out_val ? head : '0;
    assign pop     = out_val && out_rdy;
    assign push    = in_val && (!full || pop);

    seq_pipe_credit_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (in_),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
            overflow <= 1'b0;
        end else begin
            case ({issue_acc, arrive})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
            if (in_val && !push) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seq_pipe_delay_credit_queue.sv
// tb/tb_seq_pipe_delay_credit_queue.sv - scoreboard bench driving a modelled 3-stage pipe into the credit queue
module tb_seq_pipe_delay_credit_queue;
    import seq_pipe_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          issue;
    logic          issue_ok;
    logic          in_val;
    data_t         in_;
    logic          out_val;
    logic          out_rdy;
    data_t         out;
    logic [CW-1:0] count;
    logic          overflow;

    int    total = 0;
    int    bad   = 0;
    int    n;
    data_t exp_q[$];
    logic  pv [PIPE_LATENCY];
    data_t pd [PIPE_LATENCY];

    always #5 clk = ~clk;

    seq_pipe_delay_credit_queue #(.WIDTH(DEFAULT_WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .issue    (issue),
        .issue_ok (issue_ok),
        .in_val   (in_val),
        .in_      (in_),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out      (out),
        .count    (count),
        .overflow (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // One cycle: inputs change just after posedge, caller inspects at the following negedge
    task automatic step(input bit want, input data_t d, input bit rdy,
                        input bit fv = 1'b0, input data_t fd = '0, input bit rst = 1'b0);
        @(posedge clk);
        #1;
        reset   = rst;
        out_rdy = rdy;
        issue   = want && issue_ok;
        if (issue) exp_q.push_back(d);
        in_val  = pv[PIPE_LATENCY-1] | fv;
        in_     = fv ? fd : pd[PIPE_LATENCY-1];
        for (int k = PIPE_LATENCY - 1; k > 0; k--) begin
            pv[k] = pv[k-1];
            pd[k] = pd[k-1];
        end
        pv[0] = issue;
        pd[0] = d;
        if (rst) for (int k = 0; k < PIPE_LATENCY; k++) pv[k] = 1'b0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (out_val === 1'b1 && out_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got %0h want no output", out);
            end else begin
                chk("pop_data", out, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1; issue = 1'b0; in_val = 1'b0; in_ = '0; out_rdy = 1'b0;
        for (int k = 0; k < PIPE_LATENCY; k++) begin
            pv[k] = 1'b0;
            pd[k] = '0;
        end

        step(0, 8'h00, 0, 0, 8'h00, 1);
        step(0, 8'h00, 0, 0, 8'h00, 1);
        step(0, 8'h00, 0);
        chk("rst_out_val", out_val, 0);
        chk("rst_out", out, 0);
        chk("rst_count", count, 0);
        chk("rst_issue_ok", issue_ok, 1);
        chk("rst_overflow", overflow, 0);

        // single item: visible four cycles after issue
        step(1, 8'hA5, 1);
        chk("t2_issue_ok", issue_ok, 1);
        for (int i = 1; i <= 3; i++) begin
            step(0, 8'h00, 1);
            chk("t2_early_val", out_val, 0);
        end
        step(0, 8'h00, 1);
        chk("t2_val", out_val, 1);
        chk("t2_out", out, 8'hA5);
        step(0, 8'h00, 1);
        chk("t2_count", count, 0);
        chk("t2_val_low", out_val, 0);

        // fill with consumer stalled, then drain in order
        for (int i = 0; i < 4; i++) begin
            step(1, data_t'(i + 1), 0);
            chk("t3_ok_while_issuing", issue_ok, 1);
        end
        step(0, 8'h00, 0);
        chk("t3_ok_low", issue_ok, 0);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        chk("t3_count_full", count, 4);
        chk("t3_ok_full", issue_ok, 0);
        chk("t3_head", out, 8'h01);
        for (int i = 0; i < 4; i++) begin
            step(0, 8'h00, 1);
            chk("t3_drain_val", out_val, 1);
        end
        step(0, 8'h00, 1);
        chk("t3_count_empty", count, 0);
        chk("t3_ok_back", issue_ok, 1);

        // streaming 0..19 with consumer always ready, upstream honouring credits
        n = 0;
        for (int c = 0; c < 80 && !(n == 20 && exp_q.size() == 0); c++) begin
            step(n < 20, data_t'(n), 1);
            if (issue) n++;
        end
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        chk("t4_issued", n, 20);
        chk("t4_drained", exp_q.size(), 0);
        chk("t4_count", count, 0);
        chk("t4_overflow", overflow, 0);

        // overflow: forced push into a full queue
        for (int i = 0; i < 4; i++) step(1, data_t'(8'h10 + i), 0);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        chk("t5_count_full", count, 4);
        step(0, 8'h00, 0, 1, 8'hFF);
        chk("t5_ovf_before_edge", overflow, 0);
        step(0, 8'h00, 0);
        chk("t5_ovf_set", overflow, 1);
        chk("t5_count_after_drop", count, 4);
        chk("t5_head_after_drop", out, 8'h10);
        step(0, 8'h00, 1, 1, 8'hFF);
        exp_q.push_back(8'hFF);
        step(0, 8'h00, 0);
        chk("t5_count_pushpop", count, 4);
        chk("t5_ovf_sticky", overflow, 1);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1);
        step(0, 8'h00, 0);
        chk("t5_count_drained", count, 0);
        chk("t5_ovf_still", overflow, 1);

        // reset mid-stream with three queued and one in flight
        for (int i = 0; i < 4; i++) step(1, data_t'(8'h20 + i), 0);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0, 0, 8'h00, 1);
        chk("t6_count_pre", count, 3);
        chk("t6_ok_pre", issue_ok, 0);
        exp_q.delete();
        step(0, 8'h00, 0);
        chk("t6_count", count, 0);
        chk("t6_out_val", out_val, 0);
        chk("t6_out", out, 0);
        chk("t6_issue_ok", issue_ok, 1);
        chk("t6_overflow", overflow, 0);

        step(1, 8'h5A, 1);
        for (int i = 0; i < 6; i++) step(0, 8'h00, 1);
        chk("final_drained", exp_q.size(), 0);
        chk("final_count", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
